// File: rtl/square_ctrl_pkg.sv
// rtl/square_ctrl_pkg.sv - scan codes, decoder states and key bit indices for the square controller
package square_ctrl_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  // key_state is {up,left,down,right}
  localparam int KEY_RIGHT = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_UP    = 3;

  function automatic logic [3:0] arrow_mask(input logic [7:0] sc);
    logic [3:0] m;
    m = 4'b0000;
    case (sc)
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_UP:    m[KEY_UP]    = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchroniser, falling-edge sampler, parity/stop check, idle timeout
module ps2_rx #(
  parameter int TIMEOUT_CYC = 28375
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       rx_error
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // clk_sync: [0]=stage1, [1]=stage2, [2]=previous stage2
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          busy_q, busy_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic          rx_error_q, rx_error_d;
  logic          fall;
  logic          dat_bit;

  always_comb begin
    clk_sync_d   = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d   = {dat_sync_q[0], ps2_dat};
    fall         = (clk_sync_q[2:1] == 2'b10);
    dat_bit      = dat_sync_q[1];
    busy_d       = busy_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    rx_error_d   = 1'b0;

    if (!busy_q) begin
      if (fall && !dat_bit) begin
        busy_d    = 1'b1;
        bit_cnt_d = 4'd1;
        timer_d   = '0;
      end
    end else if (fall) begin
      timer_d = '0;
      if (bit_cnt_q == 4'd10) begin
        busy_d    = 1'b0;
        bit_cnt_d = 4'd0;
        // shift_q holds data[7:0] plus parity in bit 8; odd parity means odd XOR
        if ((^shift_q) && dat_bit) begin
          code_d       = shift_q[7:0];
          code_valid_d = 1'b1;
        end else begin
          rx_error_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_bit, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 3'b111;
      dat_sync_q   <= 2'b11;
      busy_q       <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      timer_q      <= '0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      rx_error_q   <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      busy_q       <= busy_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      rx_error_q   <= rx_error_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign rx_error   = rx_error_q;

endmodule

// File: rtl/square_motion_ctrl.sv
// rtl/square_motion_ctrl.sv - arrow-key decoder and per-frame clamped motion of the VGA test square
module square_motion_ctrl
  import square_ctrl_pkg::*;
#(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int SQUARE_SIZE = 10,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int STEP        = 2,
  parameter int TIMEOUT_CYC = 28375
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       frame_tick,
  output logic [9:0] sq_pos_x,
  output logic [9:0] sq_pos_y,
  output logic [3:0] key_state,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       rx_error
);

  localparam logic signed [10:0] X_MIN  = 11'(SQUARE_SIZE);
  localparam logic signed [10:0] X_MAX  = 11'(H_PIXELS - 1 - SQUARE_SIZE);
  localparam logic signed [10:0] Y_MIN  = 11'(SQUARE_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(V_PIXELS - 1 - SQUARE_SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  dec_state_t state_q, state_d;
  logic [3:0] key_q, key_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [3:0] arrow;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ps2_rx (
    .clk        (clk),
    .rst        (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .code       (code),
    .code_valid (code_valid),
    .rx_error   (rx_error)
  );

  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc, input logic dec,
                                           input logic signed [10:0] lo, input logic signed [10:0] hi);
    logic signed [10:0] p;
    p = $signed({1'b0, pos});
    if (inc && !dec)      p = p + STEP_S;
    else if (dec && !inc) p = p - STEP_S;
    if (p < lo)      p = lo;
    else if (p > hi) p = hi;
    return p[9:0];
  endfunction

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    arrow   = arrow_mask(code);
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code == SC_EXT)      state_d = EXT;
          else if (code == SC_BRK) state_d = BRK;
        end
        EXT: begin
          if (code == SC_BRK) begin
            state_d = EXT_BRK;
          end else begin
            key_d   = key_q | arrow;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          key_d   = key_q & ~arrow;
          state_d = IDLE;
        end
        BRK:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Motion reads key_q, so a key change landing with frame_tick takes effect next frame
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_tick) begin
      x_d = step_axis(x_q, key_q[KEY_RIGHT], key_q[KEY_LEFT], X_MIN, X_MAX);
      y_d = step_axis(y_q, key_q[KEY_DOWN], key_q[KEY_UP], Y_MIN, Y_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= 4'b0000;
      x_q     <= 10'(INIT_X);
      y_q     <= 10'(INIT_Y);
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign sq_pos_x  = x_q;
  assign sq_pos_y  = y_q;
  assign key_state = key_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb/tb_square_motion_ctrl.sv - self-checking bench for square_motion_ctrl against a behavioural model
module tb_square_motion_ctrl;
  import square_ctrl_pkg::*;

  localparam int HALF    = 10;
  localparam int TIMEOUT = 28375;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_dat, frame_tick;
  logic [9:0] sq_pos_x, sq_pos_y;
  logic [3:0] key_state;
  logic       code_valid, rx_error;
  logic [7:0] code;

  int errors = 0;
  int checks = 0;
  int cv_cnt = 0;
  int er_cnt = 0;

  int         mx, my;
  logic [3:0] mkeys;
  logic [7:0] arrow_code [4];

  square_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .frame_tick (frame_tick),
    .sq_pos_x   (sq_pos_x),
    .sq_pos_y   (sq_pos_y),
    .key_state  (key_state),
    .code_valid (code_valid),
    .code       (code),
    .rx_error   (rx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid === 1'b1) cv_cnt <= cv_cnt + 1;
    if (rx_error === 1'b1)   er_cnt <= er_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: one frame of motion from the currently held keys
  task automatic model_step();
    int dx, dy;
    dx = (mkeys[0] ? 2 : 0) - (mkeys[2] ? 2 : 0);
    dy = (mkeys[1] ? 2 : 0) - (mkeys[3] ? 2 : 0);
    mx = clampi(mx + dx, 10, 629);
    my = clampi(my + dy, 10, 469);
  endtask

  task automatic model_reset();
    mx = 320;
    my = 240;
    mkeys = 4'b0000;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    model_step();
    wait_cyc(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input bit tick_on_valid);
    logic [10:0] fr;
    bit seen;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && tick_on_valid) begin
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
          @(negedge clk);
          if (code_valid === 1'b1) begin
            seen = 1'b1;
            frame_tick = 1'b1;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            model_step();
          end
        end
        check("tick_with_valid_seen", {31'd0, seen}, 32'd1);
      end
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(4 * HALF);
  endtask

  task automatic send_partial(input int falls);
    for (int i = 0; i < falls; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic press(input int idx);
    send_byte(SC_EXT, 1'b0, 1'b0);
    send_byte(arrow_code[idx], 1'b0, 1'b0);
    mkeys[idx] = 1'b1;
  endtask

  task automatic release_key(input int idx, input bit tick_on_valid);
    send_byte(SC_EXT, 1'b0, 1'b0);
    send_byte(SC_BRK, 1'b0, 1'b0);
    send_byte(arrow_code[idx], 1'b0, tick_on_valid);
    mkeys[idx] = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_keys"}, {28'd0, key_state}, {28'd0, mkeys});
    check({tag, "_x"}, {22'd0, sq_pos_x}, 32'(mx));
    check({tag, "_y"}, {22'd0, sq_pos_y}, 32'(my));
  endtask

  initial begin
    int cv0, er0, r, a;
    arrow_code[0] = SC_RIGHT;
    arrow_code[1] = SC_DOWN;
    arrow_code[2] = SC_LEFT;
    arrow_code[3] = SC_UP;
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    frame_tick = 1'b0;
    model_reset();
    wait_cyc(5);
    check("rst_x", {22'd0, sq_pos_x}, 32'd320);
    check("rst_y", {22'd0, sq_pos_y}, 32'd240);
    check("rst_keys", {28'd0, key_state}, 32'd0);
    check("rst_code", {24'd0, code}, 32'd0);
    check("rst_valid", {31'd0, code_valid}, 32'd0);
    check("rst_err", {31'd0, rx_error}, 32'd0);
    reset = 1'b0;
    wait_cyc(3);

    repeat (3) tick();
    check_model("idle3");

    press(0);
    repeat (5) tick();
    check("right_keys", {28'd0, key_state}, 32'h1);
    check("right_x", {22'd0, sq_pos_x}, 32'd330);
    check_model("right5");
    release_key(0, 1'b0);
    tick();
    check("rel_keys", {28'd0, key_state}, 32'h0);
    check("rel_x", {22'd0, sq_pos_x}, 32'd330);
    check("rel_code", {24'd0, code}, 32'h74);

    press(2);
    for (int i = 0; i < 200; i++) begin
      tick();
      check("left_x", {22'd0, sq_pos_x}, 32'(mx));
    end
    check("left_clamp", {22'd0, sq_pos_x}, 32'd10);
    press(0);
    check("both_keys", {28'd0, key_state}, 32'h5);
    tick();
    check("both_x", {22'd0, sq_pos_x}, 32'd10);
    release_key(2, 1'b0);
    release_key(0, 1'b0);
    check_model("clamp_done");

    cv0 = cv_cnt;
    er0 = er_cnt;
    send_byte(SC_RIGHT, 1'b1, 1'b0);
    check("par_err_pulse", 32'(er_cnt), 32'(er0 + 1));
    check("par_no_valid", 32'(cv_cnt), 32'(cv0));
    check("par_keys", {28'd0, key_state}, {28'd0, mkeys});
    send_partial(6);
    wait_cyc(TIMEOUT + 1);
    send_byte(8'h1C, 1'b0, 1'b0);
    check("to_valid", 32'(cv_cnt), 32'(cv0 + 1));
    check("to_code", {24'd0, code}, 32'h1C);
    check("to_no_err", 32'(er_cnt), 32'(er0 + 1));

    send_byte(SC_UP, 1'b0, 1'b0);
    check("kp_make_keys", {28'd0, key_state}, 32'h0);
    send_byte(SC_BRK, 1'b0, 1'b0);
    send_byte(SC_UP, 1'b0, 1'b0);
    check("kp_brk_keys", {28'd0, key_state}, 32'h0);
    press(3);
    tick();
    check("up_y", {22'd0, sq_pos_y}, 32'd238);
    release_key(3, 1'b1);
    check("same_cycle_y", {22'd0, sq_pos_y}, 32'd236);
    check_model("same_cycle");

    press(3);
    send_partial(5);
    reset = 1'b1;
    #2;
    model_reset();
    check("mid_rst_keys", {28'd0, key_state}, 32'h0);
    check("mid_rst_x", {22'd0, sq_pos_x}, 32'd320);
    check("mid_rst_y", {22'd0, sq_pos_y}, 32'd240);
    check("mid_rst_code", {24'd0, code}, 32'd0);
    check("mid_rst_valid", {31'd0, code_valid}, 32'd0);
    check("mid_rst_err", {31'd0, rx_error}, 32'd0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(3);
    press(1);
    check("post_rst_code", {24'd0, code}, 32'h72);
    tick();
    check("post_rst_y", {22'd0, sq_pos_y}, 32'd242);
    check_model("post_rst");

    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 5);
      a = $urandom_range(0, 3);
      case (r)
        0, 1: press(a);
        2:    release_key(a, 1'b0);
        3: begin
          if ($urandom_range(0, 1) == 1) send_byte(SC_BRK, 1'b0, 1'b0);
          send_byte(arrow_code[a], 1'b0, 1'b0);
        end
        default: repeat ($urandom_range(1, 15)) tick();
      endcase
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
